sample_ring_writer: RTL and testbench
=====================================

// Module: sample_ring_writer
// PURPOSE
//  Wishbone-style bus master that sits upstream of the RAM arbiter and drives one of its ports.
//  It takes a strobed stream of 32-bit audio samples, which cannot be stalled, and buffers them in a small FIFO.
//  It writes the samples into a circular region of the shared RAM, one word per bus transaction.
//  It reports the write pointer, a wrap pulse and a sticky overflow flag, so software can read the ring behind it.
// PARAMETERS
//  WIDTH       10    word-address width; matches the arbiter/RAM address width
//  BASE        0     first word address of the ring region
//  LEN         256   ring length in words; 1..2**WIDTH-BASE
//  FIFO_DEPTH  4     sample FIFO entries; power of two, >=2
// PORTS
//  wb_clk      in   1      system clock; all logic on rising edge
//  wb_rst_n    in   1      asynchronous, active-low reset
//  en          in   1      1 = accept samples; 0 = drop new strobes, drain FIFO
//  ptr_clr     in   1      1-cycle pulse: clear ring write pointer
//  ovf_clr     in   1      1-cycle pulse: clear sticky overflow
//  s_stb       in   1      sample strobe (one sample per high cycle)
//  s_data      in   32     sample word, valid when s_stb=1
//  wb_cyc      out  1      bus request/cycle
//  wb_we       out  1      always 1 while wb_cyc=1, else 0
//  wb_sel      out  4      4'hF while wb_cyc=1, else 0
//  wb_adr      out  WIDTH  BASE+wr_ptr while wb_cyc=1, else 0
//  wb_dat      out  32     FIFO head word while wb_cyc=1, else 0
//  wb_ack      in   1      transfer complete, single cycle
//  wr_ptr      out  WIDTH  ring index of the next word to be written (0..LEN-1)
//  wrap        out  1      1-cycle pulse when wr_ptr wraps LEN-1 -> 0
//  overflow    out  1      sticky: a strobe was dropped because the FIFO was full
//  level       out  clog2(FIFO_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; state IDLE; wr_ptr=0.
//  FIFO push: s_stb & en & !full. s_stb & en & full drops the sample and sets overflow.
//   s_stb while en=0 is ignored and does not set overflow.
//  FIFO pop: on the cycle wb_ack is sampled in REQ. Push and pop in the same cycle: level unchanged.
//   A push while full in a pop cycle is still dropped; full is evaluated before the pop.
//  FSM, all outputs registered:
//   IDLE: if level!=0 -> REQ (wb_cyc=1 from the next cycle).
//   REQ:  hold wb_cyc, adr, dat, sel and we stable until wb_ack=1.
//         On ack: pop; wr_ptr <= (wr_ptr==LEN-1)?0:wr_ptr+1; wrap pulses if it wrapped; -> GAP.
//   GAP:  wb_cyc=0 for exactly one cycle, which releases the arbiter so the other port can win; -> IDLE.
//  Bus rules:
//   wb_cyc never stays high across two transfers.
//   wb_ack outside REQ is ignored.
//   No timeout; the block waits indefinitely for ack.
//  Minimum period is 4 cycles/word (IDLE, REQ with ack on its 2nd cycle, GAP); the arbiter grants on
//   cycle 1 and its ack is gated by a registered grant.
//  ptr_clr:
//   In IDLE or GAP: wr_ptr <= 0 next cycle; no wrap pulse.
//   In REQ: held pending and applied in place of the increment on ack.
//  ovf_clr: clears overflow. A drop in the same cycle wins, so overflow stays 1.
//  en falling mid-transfer: the current transfer and the remaining FIFO contents still complete.
//  Async reset mid-transfer: wb_cyc drops immediately and the FIFO contents are lost.
//  Address arithmetic is modulo 2**WIDTH; BASE+LEN-1 must not exceed 2**WIDTH-1 (checked by assertion).
// TESTING
//  1 Single strobe 0xDEADBEEF, ack 2 cycles after wb_cyc -> one write adr=BASE, dat=0xDEADBEEF,
//    sel=F, we=1; wr_ptr=1; GAP cycle has cyc=0.
//  2 LEN=4, 5 strobes spaced 8 cycles -> writes to adr 0,1,2,3,0; wrap pulses once, after the 4th ack.
//  3 FIFO_DEPTH=4, 6 back-to-back strobes, ack withheld 20 cycles -> level=4, overflow=1;
//    the first 4 samples are written in order and the last 2 are lost.
//  4 ptr_clr during REQ with wr_ptr=2 -> after ack wr_ptr=0 (not 3), no wrap; the write went to adr 2.
//  5 en=0 with 3 words queued, 5 strobes -> 3 writes complete, strobes ignored, overflow stays 0.
//  6 wb_rst_n low while wb_cyc=1 -> wb_cyc=0 asynchronously; after release level=0, wr_ptr=0, no write.

Source files
------------

// File: rtl/sample_ring_writer_if.sv
// ============================================================================
//  Module   : sample_ring_writer_if
//  Purpose  : Wishbone-style write-master bus between ring writer and arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface sample_ring_writer_if #(
    parameter int WIDTH = 10
) ();
    logic             wb_cyc;
    logic             wb_we;
    logic [3:0]       wb_sel;
    logic [WIDTH-1:0] wb_adr;
    logic [31:0]      wb_dat;
    logic             wb_ack;

    modport master (
        output wb_cyc,
        output wb_we,
        output wb_sel,
        output wb_adr,
        output wb_dat,
        input  wb_ack
    );

    modport slave (
        input  wb_cyc,
        input  wb_we,
        input  wb_sel,
        input  wb_adr,
        input  wb_dat,
        output wb_ack
    );
endinterface

`default_nettype wire

// File: rtl/sample_ring_writer.sv
// ============================================================================
//  Module   : sample_ring_writer
//  Purpose  : Buffers a non-stallable sample stream and writes it, one word
//             per bus transfer, into a circular RAM region.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sample_ring_writer #(
    parameter int WIDTH      = 10,
    parameter int BASE       = 0,
    parameter int LEN        = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                          wb_clk,
    input  wire logic                          wb_rst_n,
    input  wire logic                          en,
    input  wire logic                          ptr_clr,
    input  wire logic                          ovf_clr,
    input  wire logic                          s_stb,
    input  wire logic [31:0]                   s_data,
    sample_ring_writer_if.master               wb,
    output logic      [WIDTH-1:0]              wr_ptr,
    output logic                               wrap,
    output logic                               overflow,
    output logic      [$clog2(FIFO_DEPTH):0]   level
);

    localparam int                  c_FIFO_AW = $clog2(FIFO_DEPTH);
    localparam logic [WIDTH-1:0]    c_LAST    = WIDTH'(LEN - 1);
    localparam logic [WIDTH-1:0]    c_BASE    = WIDTH'(BASE);
    localparam logic [c_FIFO_AW:0]  c_FULL    = (c_FIFO_AW + 1)'(FIFO_DEPTH);

    generate
        if ((LEN < 1) || (BASE + LEN > 2**WIDTH) || (FIFO_DEPTH < 2) ||
            (FIFO_DEPTH != 2**c_FIFO_AW)) begin : g_param_check
            $error("sample_ring_writer: illegal BASE/LEN/FIFO_DEPTH for WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [31:0]            r_mem [FIFO_DEPTH];
    logic [c_FIFO_AW-1:0]   r_wr_idx;
    logic [c_FIFO_AW-1:0]   r_rd_idx;
    logic [c_FIFO_AW:0]     r_level;

    logic                   r_cyc;
    logic [WIDTH-1:0]       r_adr;
    logic [31:0]            r_dat;
    logic [WIDTH-1:0]       r_wr_ptr;
    logic                   r_wrap;
    logic                   r_overflow;
    logic                   r_clr_pend;

    logic                   w_full;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_pop;
    logic                   w_launch;
    logic                   w_done;
    logic [WIDTH-1:0]       w_ptr_nxt;
    logic                   w_wrap_nxt;
    logic                   w_pend_nxt;

    // Full is judged before any same-cycle pop, so a strobe into a full FIFO is lost.
    assign w_full = (r_level == c_FULL);
    assign w_push = s_stb & en & ~w_full;
    assign w_drop = s_stb & en & w_full;
    assign w_pop  = w_done;

    always_ff @(posedge wb_clk) begin
        if (w_push) begin
            r_mem[r_wr_idx] <= s_data;
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_idx <= r_wr_idx + 1'b1;
            end
            if (w_pop) begin
                r_rd_idx <= r_rd_idx + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_done      = 1'b0;
        w_ptr_nxt   = r_wr_ptr;
        w_wrap_nxt  = 1'b0;
        w_pend_nxt  = r_clr_pend;

        case (r_state)
            ST_IDLE: begin
                if (r_level != '0) begin
                    w_state_nxt = ST_REQ;
                    w_launch    = 1'b1;
                end
            end
            ST_REQ: begin
                if (wb.wb_ack) begin
                    w_state_nxt = ST_GAP;
                    w_done      = 1'b1;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A clear seen during a transfer replaces the increment when it completes.
        if (w_done) begin
            w_pend_nxt = 1'b0;
            if (ptr_clr || r_clr_pend) begin
                w_ptr_nxt = '0;
            end else if (r_wr_ptr == c_LAST) begin
                w_ptr_nxt  = '0;
                w_wrap_nxt = 1'b1;
            end else begin
                w_ptr_nxt = r_wr_ptr + 1'b1;
            end
        end else if (ptr_clr) begin
            if (r_state == ST_REQ) begin
                w_pend_nxt = 1'b1;
            end else begin
                w_ptr_nxt = '0;
            end
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_cyc      <= 1'b0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_wr_ptr   <= '0;
            r_wrap     <= 1'b0;
            r_clr_pend <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= w_ptr_nxt;
            r_wrap     <= w_wrap_nxt;
            r_clr_pend <= w_pend_nxt;

            if (w_launch) begin
                r_cyc <= 1'b1;
                r_adr <= c_BASE + w_ptr_nxt;
                r_dat <= r_mem[r_rd_idx];
            end else if (w_done) begin
                r_cyc <= 1'b0;
                r_adr <= '0;
                r_dat <= '0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign wb.wb_cyc = r_cyc;
    assign wb.wb_we  = r_cyc;
    assign wb.wb_sel = {4{r_cyc}};
    assign wb.wb_adr = r_adr;
    assign wb.wb_dat = r_dat;

    assign wr_ptr   = r_wr_ptr;
    assign wrap     = r_wrap;
    assign overflow = r_overflow;
    assign level    = r_level;

endmodule

`default_nettype wire

// File: tb/tb_sample_ring_writer.sv
// ============================================================================
//  Module   : tb_sample_ring_writer
//  Purpose  : Self-checking bench for sample_ring_writer (queue-based model).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sample_ring_writer;

    localparam int WIDTH = 10;
    localparam int BASE  = 16;
    localparam int LEN   = 4;
    localparam int DEPTH = 4;

    logic             wb_clk   = 1'b0;
    logic             wb_rst_n = 1'b0;
    logic             en       = 1'b0;
    logic             ptr_clr  = 1'b0;
    logic             ovf_clr  = 1'b0;
    logic             s_stb    = 1'b0;
    logic [31:0]      s_data   = '0;
    logic [WIDTH-1:0] wr_ptr;
    logic             wrap;
    logic             overflow;
    logic [2:0]       level;

    sample_ring_writer_if #(.WIDTH(WIDTH)) bus ();

    sample_ring_writer #(
        .WIDTH      (WIDTH),
        .BASE       (BASE),
        .LEN        (LEN),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .en       (en),
        .ptr_clr  (ptr_clr),
        .ovf_clr  (ovf_clr),
        .s_stb    (s_stb),
        .s_data   (s_data),
        .wb       (bus),
        .wr_ptr   (wr_ptr),
        .wrap     (wrap),
        .overflow (overflow),
        .level    (level)
    );

    always #5 wb_clk = ~wb_clk;

    // Reference model: sample queue, ring index, sticky flag, pending clear.
    logic [31:0]      q[$];
    int               m_ptr;
    int               m_ovf;
    int               m_pend;
    int               m_wrap;
    int               idle_wait;
    bit               prev_txn;
    bit               prev_cyc;
    logic [WIDTH-1:0] prev_adr;
    logic [31:0]      prev_dat;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0]      data;
        int               ack_wait;
        bit               clr_in_req;
        logic [WIDTH-1:0] exp_adr;
        logic [WIDTH-1:0] exp_ptr;
        bit               exp_wrap;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_ptr     = 0;
        m_ovf     = 0;
        m_pend    = 0;
        m_wrap    = 0;
        idle_wait = 0;
        prev_txn  = 1'b0;
        prev_cyc  = 1'b0;
    endtask

    // Called at a falling edge with this cycle's inputs set: checks the DUT
    // against the model, advances the model across the next rising edge.
    task automatic step();
        bit cyc;
        bit txn;
        bit full;
        cyc = bus.wb_cyc;

        chk("wr_ptr", wr_ptr, m_ptr);
        chk("overflow", overflow, m_ovf);
        chk("level", level, q.size());
        chk("wrap", wrap, m_wrap);
        if (prev_txn) chk("gap_cyc", cyc, 0);
        if (!cyc) begin
            chk("idle_bus", {bus.wb_we, bus.wb_sel, bus.wb_adr, bus.wb_dat}, 0);
        end else begin
            chk("we", bus.wb_we, 1);
            chk("sel", bus.wb_sel, 4'hF);
            if (prev_cyc && !prev_txn) begin
                chk("adr_stable", bus.wb_adr, prev_adr);
                chk("dat_stable", bus.wb_dat, prev_dat);
            end
        end

        if (q.size() != 0 && !cyc) idle_wait++;
        else idle_wait = 0;
        if (idle_wait > 3) begin
            chk("start_latency", idle_wait, 3);
            idle_wait = 0;
        end

        txn = cyc && bus.wb_ack;
        if (txn) begin
            chk("wr_adr", bus.wb_adr, BASE + m_ptr);
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wr_dat: write of %0h with no sample queued", bus.wb_dat);
            end else begin
                chk("wr_dat", bus.wb_dat, q[0]);
            end
        end

        m_wrap = 0;
        full   = (q.size() == DEPTH);
        if (txn && q.size() != 0) void'(q.pop_front());
        if (s_stb && en && full) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        if (s_stb && en && !full) q.push_back(s_data);

        if (txn) begin
            if (ptr_clr || m_pend != 0) m_ptr = 0;
            else if (m_ptr == LEN - 1) begin
                m_ptr  = 0;
                m_wrap = 1;
            end else m_ptr++;
            m_pend = 0;
        end else if (ptr_clr) begin
            if (cyc) m_pend = 1;
            else m_ptr = 0;
        end

        prev_txn = txn;
        prev_cyc = cyc;
        prev_adr = bus.wb_adr;
        prev_dat = bus.wb_dat;

        @(negedge wb_clk);
        s_stb      = 1'b0;
        ptr_clr    = 1'b0;
        ovf_clr    = 1'b0;
        bus.wb_ack = 1'b0;
    endtask

    task automatic drain();
        int guard;
        int w;
        guard = 0;
        w     = $urandom_range(0, 2);
        while ((q.size() != 0 || bus.wb_cyc) && guard < 200) begin
            if (bus.wb_cyc) begin
                if (w == 0) begin
                    bus.wb_ack = 1'b1;
                    w = $urandom_range(0, 2);
                end else w--;
            end
            step();
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d samples left, expected 0", q.size());
        end
        step();
    endtask

    task automatic write_one(input vec_t v);
        int n;
        s_stb  = 1'b1;
        s_data = v.data;
        step();
        n = 0;
        while (!bus.wb_cyc && n < 10) begin
            step();
            n++;
        end
        chk("launch_latency", n, 1);
        for (int k = 0; k < v.ack_wait; k++) begin
            if (v.clr_in_req && k == 0) ptr_clr = 1'b1;
            step();
        end
        chk("tbl_adr", bus.wb_adr, v.exp_adr);
        chk("tbl_dat", bus.wb_dat, v.data);
        bus.wb_ack = 1'b1;
        step();
        chk("tbl_ptr", wr_ptr, v.exp_ptr);
        chk("tbl_wrap", wrap, v.exp_wrap);
        chk("tbl_gap", bus.wb_cyc, 0);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'hDEADBEEF, 1, 1'b0, 10'd16, 10'd1, 1'b0};
        tbl[1] = '{32'h11111111, 1, 1'b0, 10'd17, 10'd2, 1'b0};
        tbl[2] = '{32'h22222222, 3, 1'b1, 10'd18, 10'd0, 1'b0};
        tbl[3] = '{32'h33333333, 0, 1'b0, 10'd16, 10'd1, 1'b0};
        tbl[4] = '{32'h44444444, 2, 1'b0, 10'd17, 10'd2, 1'b0};
        tbl[5] = '{32'h55555555, 1, 1'b0, 10'd18, 10'd3, 1'b0};
        tbl[6] = '{32'h66666666, 1, 1'b0, 10'd19, 10'd0, 1'b1};
        tbl[7] = '{32'h77777777, 1, 1'b0, 10'd16, 10'd1, 1'b0};

        bus.wb_ack = 1'b0;
        m_reset();
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        step();
        step();

        // Single writes around the ring, including a clear during a transfer.
        en = 1'b1;
        for (int i = 0; i < 8; i++) write_one(tbl[i]);

        // Back-to-back burst with the ack withheld.
        for (int i = 0; i < 6; i++) begin
            s_stb  = 1'b1;
            s_data = $urandom;
            step();
        end
        repeat (20) step();
        chk("burst_level", level, 4);
        chk("burst_ovf", overflow, 1);
        s_stb   = 1'b1;
        s_data  = 32'hBAD0BAD0;
        ovf_clr = 1'b1;
        step();
        chk("ovf_clr_vs_drop", overflow, 1);
        ovf_clr = 1'b1;
        step();
        chk("ovf_clr", overflow, 0);
        drain();

        // Strobes while disabled are ignored; queued words still go out.
        for (int i = 0; i < 3; i++) begin
            s_stb  = 1'b1;
            s_data = 32'hA0000000 + i;
            step();
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_stb  = 1'b1;
            s_data = 32'hC0000000 + i;
            if (bus.wb_cyc) bus.wb_ack = 1'b1;
            step();
        end
        drain();
        chk("en0_level", level, 0);
        chk("en0_ovf", overflow, 0);

        // Randomized traffic.
        en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            s_stb  = ($urandom_range(0, 2) == 0);
            s_data = $urandom;
            if ($urandom_range(0, 49) == 0) en = ~en;
            ptr_clr = ($urandom_range(0, 39) == 0);
            ovf_clr = ($urandom_range(0, 29) == 0);
            if (bus.wb_cyc) bus.wb_ack = ($urandom_range(0, 2) == 0);
            else bus.wb_ack = ($urandom_range(0, 19) == 0);
            step();
        end
        en = 1'b1;
        drain();

        // Asynchronous reset in the middle of a transfer.
        s_stb  = 1'b1;
        s_data = 32'h5A5A5A5A;
        step();
        for (int i = 0; i < 10 && !bus.wb_cyc; i++) step();
        chk("pre_reset_cyc", bus.wb_cyc, 1);
        #2 wb_rst_n = 1'b0;
        #1;
        chk("async_rst_cyc", bus.wb_cyc, 0);
        chk("async_rst_level", level, 0);
        chk("async_rst_ptr", wr_ptr, 0);
        m_reset();
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("post_reset_cyc", bus.wb_cyc, 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
